// File: rtl/usb_keycode_reader.sv
// usb_keycode_reader
// Periodically scans the USB keycode mailbox through a read-only Avalon-MM
// port (1-cycle read latency) and turns HID boot-keyboard keycodes into
// game control flags.
//
// Ports:
//   i_clk            system clock, rising edge
//   i_reset_n        asynchronous active-low reset
//   i_enable         scanning permitted when high (sampled in IDLE only)
//   o_address        mailbox word address
//   o_chipselect     mailbox access strobe
//   o_write          tied 0
//   o_byteenable     tied 4'hF
//   o_writedata      tied 0
//   i_readdata       mailbox data, valid the cycle after the address
//   o_keys_held      key levels {bomb, fire, right, left, down, up}
//   o_keys_pressed   one-cycle rising-edge pulses, same bit order
//   o_frame_valid    one-cycle pulse at the end of every scan
//   o_rollover       last scan contained error code 0x01
//   o_busy           scan in progress
module usb_keycode_reader #(
    parameter int unsigned POLL_CYCLES = 833333,
    parameter int unsigned NUM_WORDS   = 2,
    parameter int unsigned BASE_ADDR   = 0
) (
    input  logic        i_clk,
    input  logic        i_reset_n,
    input  logic        i_enable,
    output logic [7:0]  o_address,
    output logic        o_chipselect,
    output logic        o_write,
    output logic [3:0]  o_byteenable,
    output logic [31:0] o_writedata,
    input  logic [31:0] i_readdata,
    output logic [5:0]  o_keys_held,
    output logic [5:0]  o_keys_pressed,
    output logic        o_frame_valid,
    output logic        o_rollover,
    output logic        o_busy
);

    localparam int unsigned CNT_W = (POLL_CYCLES > 1) ? $clog2(POLL_CYCLES) : 1;
    localparam int unsigned IDX_W = $clog2(NUM_WORDS) + 1;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(POLL_CYCLES - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_WORDS - 1);
    localparam logic [7:0]       BASE8    = 8'(BASE_ADDR);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_READ    = 2'd1;
    localparam logic [1:0] ST_CAPTURE = 2'd2;
    localparam logic [1:0] ST_UPDATE  = 2'd3;

    logic [1:0]       r_state,        w_state_d;
    logic [CNT_W-1:0] r_cnt,          w_cnt_d;
    logic [IDX_W-1:0] r_idx,          w_idx_d;
    logic [5:0]       r_acc,          w_acc_d;
    logic             r_err,          w_err_d;
    logic [7:0]       r_address,      w_address_d;
    logic             r_chipselect,   w_chipselect_d;
    logic [5:0]       r_keys_held,    w_keys_held_d;
    logic [5:0]       r_keys_pressed, w_keys_pressed_d;
    logic             r_frame_valid,  w_frame_valid_d;
    logic             r_rollover,     w_rollover_d;

    logic [5:0]       w_decoded;
    logic             w_err_hit;
    logic [IDX_W-1:0] w_idx_next;

    // Bit order: [0] up, [1] down, [2] left, [3] right, [4] fire, [5] bomb.
    function automatic logic [5:0] decode_key(input logic [7:0] code);
        logic [5:0] bits;
        bits = 6'b000000;
        case (code)
            8'h1A, 8'h52: bits = 6'b000001;
            8'h16, 8'h51: bits = 6'b000010;
            8'h04, 8'h50: bits = 6'b000100;
            8'h07, 8'h4F: bits = 6'b001000;
            8'h2C:        bits = 6'b010000;
            8'h05:        bits = 6'b100000;
            default:      bits = 6'b000000;
        endcase
        return bits;
    endfunction

    always_comb begin
        w_decoded = 6'b000000;
        w_err_hit = 1'b0;
        for (int b = 0; b < 4; b++) begin
            w_decoded = w_decoded | decode_key(i_readdata[8*b +: 8]);
            if (i_readdata[8*b +: 8] == 8'h01) begin
                w_err_hit = 1'b1;
            end
        end
    end

    assign w_idx_next = r_idx + IDX_W'(1);

    always_comb begin
        w_state_d        = r_state;
        w_cnt_d          = r_cnt;
        w_idx_d          = r_idx;
        w_acc_d          = r_acc;
        w_err_d          = r_err;
        w_address_d      = r_address;
        w_chipselect_d   = 1'b0;
        w_keys_held_d    = r_keys_held;
        w_keys_pressed_d = 6'b000000;
        w_frame_valid_d  = 1'b0;
        w_rollover_d     = r_rollover;

        case (r_state)
            ST_IDLE: begin
                if (!i_enable) begin
                    w_cnt_d = '0;
                end else if (r_cnt == CNT_LAST) begin
                    w_cnt_d        = '0;
                    w_acc_d        = 6'b000000;
                    w_err_d        = 1'b0;
                    w_idx_d        = '0;
                    // Address/strobe are registered so they are valid during READ.
                    w_address_d    = BASE8;
                    w_chipselect_d = 1'b1;
                    w_state_d      = ST_READ;
                end else begin
                    w_cnt_d = r_cnt + CNT_W'(1);
                end
            end
            ST_READ: begin
                w_state_d = ST_CAPTURE;
            end
            ST_CAPTURE: begin
                w_acc_d = r_acc | w_decoded;
                if (w_err_hit) begin
                    w_err_d = 1'b1;
                end
                if (r_idx < IDX_LAST) begin
                    w_idx_d        = w_idx_next;
                    w_address_d    = BASE8 + 8'(w_idx_next);
                    w_chipselect_d = 1'b1;
                    w_state_d      = ST_READ;
                end else begin
                    w_state_d = ST_UPDATE;
                end
            end
            ST_UPDATE: begin
                w_frame_valid_d = 1'b1;
                w_rollover_d    = r_err;
                // A scan with rollover is untrustworthy: publish nothing new.
                if (!r_err) begin
                    w_keys_held_d    = r_acc;
                    w_keys_pressed_d = r_acc & ~r_keys_held;
                end
                w_state_d = ST_IDLE;
            end
            default: begin
                w_state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state        <= ST_IDLE;
            r_cnt          <= '0;
            r_idx          <= '0;
            r_acc          <= 6'b000000;
            r_err          <= 1'b0;
            r_address      <= 8'h00;
            r_chipselect   <= 1'b0;
            r_keys_held    <= 6'b000000;
            r_keys_pressed <= 6'b000000;
            r_frame_valid  <= 1'b0;
            r_rollover     <= 1'b0;
        end else begin
            r_state        <= w_state_d;
            r_cnt          <= w_cnt_d;
            r_idx          <= w_idx_d;
            r_acc          <= w_acc_d;
            r_err          <= w_err_d;
            r_address      <= w_address_d;
            r_chipselect   <= w_chipselect_d;
            r_keys_held    <= w_keys_held_d;
            r_keys_pressed <= w_keys_pressed_d;
            r_frame_valid  <= w_frame_valid_d;
            r_rollover     <= w_rollover_d;
        end
    end

    assign o_address      = r_address;
    assign o_chipselect   = r_chipselect;
    assign o_write        = 1'b0;
    assign o_byteenable   = 4'hF;
    assign o_writedata    = 32'h0000_0000;
    assign o_keys_held    = r_keys_held;
    assign o_keys_pressed = r_keys_pressed;
    assign o_frame_valid  = r_frame_valid;
    assign o_rollover     = r_rollover;
    assign o_busy         = (r_state != ST_IDLE);

endmodule

// File: tb/tb_usb_keycode_reader.sv
// Testbench for usb_keycode_reader: table-driven frame vectors plus
// hand-written sequences for first-scan timing, enable gating, address wrap
// and reset during a scan.
module tb_usb_keycode_reader;

    localparam int unsigned P = 4;
    localparam int unsigned N = 2;

    logic        clk;
    logic        rst_n;
    logic        enable;

    logic [7:0]  addr_a;
    logic        cs_a;
    logic        wr_a;
    logic [3:0]  be_a;
    logic [31:0] wd_a;
    logic [31:0] rdata_a;
    logic [5:0]  held_a;
    logic [5:0]  pressed_a;
    logic        fv_a;
    logic        roll_a;
    logic        busy_a;

    logic [7:0]  addr_b;
    logic        cs_b;
    logic        wr_b;
    logic [3:0]  be_b;
    logic [31:0] wd_b;
    logic [31:0] rdata_b;
    logic [5:0]  held_b;
    logic [5:0]  pressed_b;
    logic        fv_b;
    logic        roll_b;
    logic        busy_b;

    logic [31:0] mem [256];

    int errors = 0;
    int checks = 0;
    int pulse_viol = 0;
    logic [7:0] addr_log_a[$];
    logic [7:0] addr_log_b[$];

    usb_keycode_reader #(.POLL_CYCLES(P), .NUM_WORDS(N), .BASE_ADDR(0)) dut_a (
        .i_clk(clk), .i_reset_n(rst_n), .i_enable(enable),
        .o_address(addr_a), .o_chipselect(cs_a), .o_write(wr_a),
        .o_byteenable(be_a), .o_writedata(wd_a), .i_readdata(rdata_a),
        .o_keys_held(held_a), .o_keys_pressed(pressed_a),
        .o_frame_valid(fv_a), .o_rollover(roll_a), .o_busy(busy_a)
    );

    usb_keycode_reader #(.POLL_CYCLES(P), .NUM_WORDS(N), .BASE_ADDR(255)) dut_b (
        .i_clk(clk), .i_reset_n(rst_n), .i_enable(enable),
        .o_address(addr_b), .o_chipselect(cs_b), .o_write(wr_b),
        .o_byteenable(be_b), .o_writedata(wd_b), .i_readdata(rdata_b),
        .o_keys_held(held_b), .o_keys_pressed(pressed_b),
        .o_frame_valid(fv_b), .o_rollover(roll_b), .o_busy(busy_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous mailbox RAM with 1-cycle read latency.
    always @(posedge clk) begin
        if (cs_a) rdata_a <= mem[addr_a];
    end
    assign rdata_b = 32'h0000_0000;

    always @(negedge clk) begin
        if (rst_n && cs_a && addr_log_a.size() < 2) addr_log_a.push_back(addr_a);
        if (rst_n && cs_b && addr_log_b.size() < 3) addr_log_b.push_back(addr_b);
        if (rst_n && pressed_a != 6'b0 && !fv_a) pulse_viol++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Counts negedges until frame_valid is seen; -1 on timeout.
    task automatic wait_fv(input int limit, output int n);
        bit found;
        found = 1'b0;
        n = 0;
        for (int k = 0; k < limit && !found; k++) begin
            @(negedge clk);
            n++;
            if (fv_a) found = 1'b1;
        end
        if (!found) n = -1;
    endtask

    // Confirms the pulses last exactly one cycle.
    task automatic check_pulse_end(input string name);
        @(negedge clk);
        check({name, "_fv_drop"}, {31'b0, fv_a}, 32'd0);
        check({name, "_pressed_drop"}, {26'b0, pressed_a}, 32'd0);
    endtask

    typedef struct {
        logic [31:0] w0;
        logic [31:0] w1;
        logic [5:0]  held;
        logic [5:0]  pressed;
        logic        roll;
    } vec_t;

    vec_t vecs[9];

    initial begin
        int n;
        int bad;

        vecs[0] = '{32'h0000001A, 32'h00000000, 6'b000001, 6'b000000, 1'b0};
        vecs[1] = '{32'h00000000, 32'h00000000, 6'b000000, 6'b000000, 1'b0};
        vecs[2] = '{32'h2C4F0552, 32'h00000000, 6'b111001, 6'b111001, 1'b0};
        vecs[3] = '{32'h0000001A, 32'h00000000, 6'b000001, 6'b000000, 1'b0};
        vecs[4] = '{32'h01010101, 32'h00000000, 6'b000001, 6'b000000, 1'b1};
        vecs[5] = '{32'h00000016, 32'h00000050, 6'b000110, 6'b000110, 1'b0};
        vecs[6] = '{32'h00000000, 32'h00070451, 6'b001110, 6'b001000, 1'b0};
        vecs[7] = '{32'h00000007, 32'h01000000, 6'b001110, 6'b000000, 1'b1};
        vecs[8] = '{32'h00FF3300, 32'h00000000, 6'b000000, 6'b000000, 1'b0};

        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        mem[0] = 32'h0000001A;
        mem[1] = 32'h00000000;
        rst_n  = 1'b0;
        enable = 1'b1;
        repeat (3) @(negedge clk);

        check("reset_held", {26'b0, held_a}, 32'd0);
        check("reset_cs_busy_fv", {29'b0, cs_a, busy_a, fv_a}, 32'd0);
        check("reset_addr", {24'b0, addr_a}, 32'd0);
        check("const_bus", {wr_a, be_a, wd_a[26:0]}, {1'b0, 4'hF, 27'd0});

        // First scan: frame_valid on cycle 9 after release.
        rst_n = 1'b1;
        wait_fv(40, n);
        check("first_frame_cycle", n, 32'd9);
        check("first_held", {26'b0, held_a}, 32'h01);
        check("first_pressed", {26'b0, pressed_a}, 32'h01);
        check("first_roll", {31'b0, roll_a}, 32'd0);
        check_pulse_end("first");

        for (int i = 0; i < 9; i++) begin
            mem[0] = vecs[i].w0;
            mem[1] = vecs[i].w1;
            wait_fv(40, n);
            check($sformatf("v%0d_period", i), n, 32'd8);
            check($sformatf("v%0d_held", i), {26'b0, held_a}, {26'b0, vecs[i].held});
            check($sformatf("v%0d_pressed", i), {26'b0, pressed_a}, {26'b0, vecs[i].pressed});
            check($sformatf("v%0d_roll", i), {31'b0, roll_a}, {31'b0, vecs[i].roll});
            check_pulse_end($sformatf("v%0d", i));
        end

        check("addr_a_0", (addr_log_a.size() > 0) ? {24'b0, addr_log_a[0]} : 32'hDEAD, 32'd0);
        check("addr_a_1", (addr_log_a.size() > 1) ? {24'b0, addr_log_a[1]} : 32'hDEAD, 32'd1);
        check("addr_wrap_0", (addr_log_b.size() > 0) ? {24'b0, addr_log_b[0]} : 32'hDEAD, 32'd255);
        check("addr_wrap_1", (addr_log_b.size() > 1) ? {24'b0, addr_log_b[1]} : 32'hDEAD, 32'd0);
        check("addr_wrap_2", (addr_log_b.size() > 2) ? {24'b0, addr_log_b[2]} : 32'hDEAD, 32'd255);

        // Enable low for 20 cycles: no access, no frame; counter restarts at 0.
        mem[0] = 32'h0000001A;
        mem[1] = 32'h00000000;
        enable = 1'b0;
        bad = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (cs_a || fv_a || busy_a) bad++;
        end
        check("disabled_quiet", bad, 32'd0);
        enable = 1'b1;
        wait_fv(40, n);
        check("reenable_cycle", n, 32'd9);
        check("reenable_held", {26'b0, held_a}, 32'h01);
        check("reenable_pressed", {26'b0, pressed_a}, 32'h01);
        check_pulse_end("reenable");

        // Reset during CAPTURE.
        n = 0;
        for (int k = 0; k < 40 && !cs_a; k++) @(negedge clk);
        check("reached_read", {31'b0, cs_a}, 32'd1);
        @(negedge clk);
        check("capture_busy", {30'b0, busy_a, cs_a}, 32'b10);
        rst_n = 1'b0;
        #1;
        check("midreset_held", {26'b0, held_a}, 32'd0);
        check("midreset_flags", {28'b0, busy_a, cs_a, fv_a, roll_a}, 32'd0);
        check("midreset_addr", {24'b0, addr_a}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        wait_fv(40, n);
        check("post_reset_cycle", n, 32'd9);
        check("post_reset_held", {26'b0, held_a}, 32'h01);
        check("post_reset_pressed", {26'b0, pressed_a}, 32'h01);
        check_pulse_end("post_reset");

        check("pressed_only_with_fv", pulse_viol, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish, required finish");
        $fatal(1);
    end

endmodule

// File: doc/usb_keycode_reader.md
# usb_keycode_reader

Hardware-side consumer of the USB keycode mailbox RAM. The NIOS USB driver writes HID boot-keyboard keycodes into the mailbox's first port. This block periodically reads the mailbox's second Avalon-MM port, decodes the keycodes into game control flags (held levels and one-cycle press pulses) and hands them to the Raiden game logic. It is a read-only Avalon master on a synchronous RAM port with 1-cycle read latency.

## Interface
Parameters:
- POLL_CYCLES, 833333: idle cycles between scans (60 Hz at 50 MHz). Legal values are at least 2.
- NUM_WORDS, 2: number of 32-bit mailbox words per scan (4 keycodes per word). Legal range is 1..64.
- BASE_ADDR, 0: word address of the first keycode word.

Ports:
- clk  in  1  single system clock; all logic runs on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- enable  in  1  scanning permitted when high.
- address  out  8  mailbox word address.
- chipselect  out  1  mailbox access strobe.
- write  out  1  constant 0.
- byteenable  out  4  constant 4'hF.
- writedata  out  32  constant 0.
- readdata  in  32  mailbox data. Valid on the cycle after the address is presented.
- keys_held  out  6  current key levels: [0] up, [1] down, [2] left, [3] right, [4] fire, [5] bomb.
- keys_pressed  out  6  one-cycle rising-edge pulses, using the same bit order as keys_held.
- frame_valid  out  1  one-cycle pulse at the end of every scan.
- rollover  out  1  registered flag; high when the last scan contained error code 0x01.
- busy  out  1  high while a scan is in progress (any state other than IDLE).

## Operation
- Key map (byte value to bit):
  - 0x1A (W) or 0x52 (Up arrow) → up
  - 0x16 (S) or 0x51 (Down arrow) → down
  - 0x04 (A) or 0x50 (Left arrow) → left
  - 0x07 (D) or 0x4F (Right arrow) → right
  - 0x2C (Space) → fire
  - 0x05 (B) → bomb
  - 0x00 and all other values are ignored.
  - Duplicate codes within a scan OR together.
- FSM states are IDLE, READ, CAPTURE, UPDATE.
- IDLE:
  - chipselect=0.
  - The poll counter counts only while in IDLE and enable=1. It is held at 0 while enable=0.
  - When the counter equals POLL_CYCLES-1: clear the counter, clear the accumulator and the error flag, set the word index to 0, and go to READ.
- READ:
  - Drive address = BASE_ADDR + index (truncated to 8 bits, so it wraps mod 256) with chipselect=1 for exactly one cycle.
  - Go to CAPTURE.
- CAPTURE:
  - chipselect=0.
  - Decode all 4 bytes of readdata and OR the results into the 6-bit accumulator.
  - If any byte is 0x01, set the error flag.
  - If index < NUM_WORDS-1: increment index and go to READ. Otherwise go to UPDATE.
- UPDATE:
  - Pulse frame_valid. Register rollover = error flag.
  - If the error flag is clear: keys_held ← accumulator, and keys_pressed ← accumulator & ~old keys_held for this one cycle.
  - If the error flag is set: keys_held keeps its value and keys_pressed stays 0.
  - Go to IDLE.
- enable is sampled only in IDLE. A scan that has already started always completes.
- The counter width is clog2(POLL_CYCLES). The index width is clog2(NUM_WORDS)+1.

## Timing
- Reset values (asynchronous): state=IDLE, counter=0, index=0, accumulator=0, address=0, chipselect=0, keys_held=0, keys_pressed=0, frame_valid=0, rollover=0, busy=0.
- The first scan leaves IDLE POLL_CYCLES cycles after reset_n rises, provided enable=1 throughout.
- One scan occupies 2·NUM_WORDS+1 cycles (READ/CAPTURE pairs, then UPDATE). The poll period is POLL_CYCLES + 2·NUM_WORDS + 1 cycles.
- readdata is sampled in the cycle immediately after the READ cycle.
- keys_held, keys_pressed and frame_valid all change at the same clock edge, the one ending UPDATE.
- keys_pressed is nonzero for exactly one cycle per scan and is coincident with frame_valid.
- If reset_n is asserted mid-scan, the scan is aborted immediately and all registers return to their reset values. No partial frame is published.
- Mailbox writes by the NIOS during a scan are allowed. Per-word atomicity is provided by the RAM; a frame may mix old and new words.

## Test plan
- Reset and first scan: POLL_CYCLES=4, NUM_WORDS=2, mailbox words = 0x0000001A and 0x00000000 → chipselect pulses at address 0, then address 1 → keys_held=6'b000001, keys_pressed=6'b000001, frame_valid pulses on cycle 9 after reset release.
- Hold then release: the next scan reads the same data → keys_pressed=0 and keys_held unchanged. Then set word 0 = 0 → keys_held=0 and keys_pressed=0.
- Multi-key and arrows: word 0 = 0x2C4F0552 → keys_held=6'b111001, keys_pressed=6'b111001.
- Rollover: word 0 = 0x01010101 while keys_held=6'b000001 → rollover=1, keys_held stays 6'b000001, keys_pressed=0, frame_valid pulses. The next clean frame clears rollover.
- Address wrap and enable: BASE_ADDR=255, NUM_WORDS=2 → addresses 255, then 0. With enable=0 held for 20 cycles → chipselect stays 0, no frame_valid, counter restarts from 0 when enable returns high.
- Reset mid-scan: assert reset_n=0 during CAPTURE → busy=0, all outputs 0 immediately. After release, the first scan again occurs after POLL_CYCLES cycles.
